// File: rtl/ttl_377_bank_write_arbiter.sv
// ttl_377_bank_write_arbiter
//
// Shares one write path into a bank of 74377 octal D flip-flops among several
// agents. Each cycle the block picks one eligible requester, drives its data
// on the shared D bus, and pulls low the Enable_bar of the addressed register
// for exactly one cycle. The 74377 captures the D bus at the edge that ends
// that cycle. The winner sees a one-cycle Grant pulse during the same cycle.
//
// Handshake: an agent holds Req high until it has seen its Grant. It drops Req
// at the edge that ends its Grant cycle. At that edge the current grantee is
// not eligible, so a write is never repeated and a lone agent that keeps its
// request up wins only every other cycle.
//
// Configuration macro:
//   REG_BANK_ARB_FIXED_PRI_EN  defined   -> fixed priority, lowest index wins
//                              undefined -> round robin (default)
//
// Ports:
//   Clk         in   rising-edge clock, shared with the 74377 bank
//   Clear_bar   in   asynchronous active-low reset
//   Req         in   [REQUESTERS]            write request per agent
//   Addr        in   [REQUESTERS*ADDR_BITS]  target register per agent
//   Data        in   [REQUESTERS*WIDTH]      write data per agent
//   Grant       out  [REQUESTERS]            one-hot, high during the LOAD cycle
//   Busy        out                          high while in LOAD
//   D_bus       out  [WIDTH]                 shared data to the 74377 D inputs
//   Enable_bar  out  [NUM_REGS]              active-low enable per 74377
module ttl_377_bank_write_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int NUM_REGS   = 4,
    parameter int WIDTH      = 8,
    parameter int ADDR_BITS  = 2
) (
    input  logic                            Clk,
    input  logic                            Clear_bar,
    input  logic [REQUESTERS-1:0]           Req,
    input  logic [REQUESTERS*ADDR_BITS-1:0] Addr,
    input  logic [REQUESTERS*WIDTH-1:0]     Data,
    output logic [REQUESTERS-1:0]           Grant,
    output logic                            Busy,
    output logic [WIDTH-1:0]                D_bus,
    output logic [NUM_REGS-1:0]             Enable_bar
);

    localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam logic [REQUESTERS-1:0] GRANT_ONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                state;
    logic [REQUESTERS-1:0] eligible;
    logic                  found;
    int                    win_idx;
    logic [ADDR_BITS-1:0]  win_addr;
    logic [NUM_REGS-1:0]   en_next;

    // The agent being granted right now still shows Req high at the edge
    // that ends its grant; masking it here stops a repeated write.
    assign eligible = Req & ~Grant;

`ifdef REG_BANK_ARB_FIXED_PRI_EN
    // Lowest eligible index wins: scan downwards, the last hit is the lowest.
    always_comb begin
        found   = 1'b0;
        win_idx = 0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                found   = 1'b1;
                win_idx = k;
            end
        end
    end
`else
    // ptr holds the index where the next search starts (last grantee + 1).
    logic [PTR_W-1:0] ptr;
    int               cand;

    always_comb begin
        found   = 1'b0;
        win_idx = 0;
        cand    = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= REQUESTERS) begin
                cand = cand - REQUESTERS;
            end
            if (!found && eligible[cand[PTR_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end
`endif

    assign win_addr = Addr[win_idx*ADDR_BITS +: ADDR_BITS];

    // An address beyond the bank matches no register, so the write is dropped
    // while Grant and D_bus still behave normally.
    always_comb begin
        en_next = '1;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (int'(win_addr) == r) begin
                en_next[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state      <= IDLE;
            Grant      <= '0;
            Busy       <= 1'b0;
            D_bus      <= '0;
            Enable_bar <= '1;
`ifndef REG_BANK_ARB_FIXED_PRI_EN
            ptr        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= LOAD;
                        Grant      <= GRANT_ONE << win_idx;
                        Busy       <= 1'b1;
                        D_bus      <= Data[win_idx*WIDTH +: WIDTH];
                        Enable_bar <= en_next;
`ifndef REG_BANK_ARB_FIXED_PRI_EN
                        ptr        <= (win_idx == REQUESTERS - 1) ? '0 : PTR_W'(win_idx + 1);
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    if (found) begin
                        state      <= LOAD;
                        Grant      <= GRANT_ONE << win_idx;
                        Busy       <= 1'b1;
                        D_bus      <= Data[win_idx*WIDTH +: WIDTH];
                        Enable_bar <= en_next;
`ifndef REG_BANK_ARB_FIXED_PRI_EN
                        ptr        <= (win_idx == REQUESTERS - 1) ? '0 : PTR_W'(win_idx + 1);
`endif
                    end else begin
                        // D_bus keeps its last value on the way back to IDLE.
                        state      <= IDLE;
                        Grant      <= '0;
                        Busy       <= 1'b0;
                        Enable_bar <= '1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttl_377_bank_write_arbiter.sv
// Directed bench for ttl_377_bank_write_arbiter: two arbiter instances (a
// four-register bank and a three-register bank) each feeding behavioural
// 74377 register models clocked on the shared clock.
module tb_ttl_377_bank_write_arbiter;

    logic clk = 1'b0;
    logic clear_bar = 1'b1;

    always #5 clk = ~clk;

    // Four-register bank
    logic [3:0]  req  = '0;
    logic [7:0]  addr = '0;
    logic [31:0] data = '0;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  d_bus;
    logic [3:0]  en_b;

    // Three-register bank, used for the out-of-range address case
    logic [3:0]  req3  = '0;
    logic [7:0]  addr3 = '0;
    logic [31:0] data3 = '0;
    logic [3:0]  grant3;
    logic        busy3;
    logic [7:0]  d_bus3;
    logic [2:0]  en_b3;

    ttl_377_bank_write_arbiter u_dut (
        .Clk        (clk),
        .Clear_bar  (clear_bar),
        .Req        (req),
        .Addr       (addr),
        .Data       (data),
        .Grant      (grant),
        .Busy       (busy),
        .D_bus      (d_bus),
        .Enable_bar (en_b)
    );

    ttl_377_bank_write_arbiter #(.NUM_REGS(3)) u_dut3 (
        .Clk        (clk),
        .Clear_bar  (clear_bar),
        .Req        (req3),
        .Addr       (addr3),
        .Data       (data3),
        .Grant      (grant3),
        .Busy       (busy3),
        .D_bus      (d_bus3),
        .Enable_bar (en_b3)
    );

    // 74377 models: load D when enable is low at the rising edge.
    logic [7:0] q  [4];
    logic [7:0] q3 [3];

    initial begin
        for (int r = 0; r < 4; r++) q[r] = 8'h00;
        for (int r = 0; r < 3; r++) q3[r] = 8'h00;
    end

    always @(posedge clk) begin
        for (int r = 0; r < 4; r++) if (en_b[r] == 1'b0) q[r] <= d_bus;
        for (int r = 0; r < 3; r++) if (en_b3[r] == 1'b0) q3[r] <= d_bus3;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Expected sequences for the round-robin test (agent i -> register 3-i).
    logic [3:0] rr_grant [5];
    logic [3:0] rr_en    [5];
    logic [7:0] rr_dbus  [5];
    logic [3:0] fp_grant [4];
    logic [3:0] lone_grant [4];
    logic       lone_busy  [4];
    logic [7:0] exp_q0;

    initial begin
        rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_en    = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111};
        rr_dbus  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        fp_grant = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        lone_grant = '{4'b1000, 4'b0000, 4'b1000, 4'b0000};
        lone_busy  = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset asserted mid-cycle: outputs settle with no clock edge.
        #3;
        clear_bar = 1'b0;
        #1;
        check("rst_en_b",  32'(en_b),  32'hF);
        check("rst_d_bus", 32'(d_bus), 32'h00);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_en_b3", 32'(en_b3), 32'h7);
        next_edge();
        next_edge();
        clear_bar = 1'b1;
        next_edge();

        // Single write: agent 1 -> register 2, data A5.
        req  = 4'b0010;
        addr = 8'b00_00_10_00;
        data = 32'h0000_A500;
        next_edge();
        check("sw_grant", 32'(grant), 32'h2);
        check("sw_en_b",  32'(en_b),  32'hB);
        check("sw_d_bus", 32'(d_bus), 32'hA5);
        check("sw_busy",  32'(busy),  32'h1);
        next_edge();
        req = 4'b0000;
        check("sw_q2",      32'(q[2]),  32'hA5);
        check("sw_en_idle", 32'(en_b),  32'hF);
        check("sw_busy0",   32'(busy),  32'h0);
        check("sw_grant0",  32'(grant), 32'h0);
        check("sw_dbus_hold", 32'(d_bus), 32'hA5);

        // Reset again mid-cycle so the pointer restarts at agent 0.
        #3;
        clear_bar = 1'b0;
        #1;
        check("rst2_dbus", 32'(d_bus), 32'h00);
        next_edge();
        clear_bar = 1'b1;
        addr = 8'b00_01_10_11;
        data = 32'h4433_2211;

`ifndef REG_BANK_ARB_FIXED_PRI_EN
        // Round robin with all four agents requesting.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            next_edge();
            check($sformatf("rr_grant%0d", i), 32'(grant), 32'(rr_grant[i]));
            check($sformatf("rr_en%0d", i),    32'(en_b),  32'(rr_en[i]));
            check($sformatf("rr_dbus%0d", i),  32'(d_bus), 32'(rr_dbus[i]));
        end
        req = 4'b0000;
        next_edge();
        check("rr_idle_busy", 32'(busy), 32'h0);
        check("rr_q3", 32'(q[3]), 32'h11);
        check("rr_q2", 32'(q[2]), 32'h22);
        check("rr_q1", 32'(q[1]), 32'h33);
        check("rr_q0", 32'(q[0]), 32'h44);
        exp_q0 = 8'h44;
`else
        // Fixed priority: agents 0 and 1 alternate.
        req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            next_edge();
            check($sformatf("fp_grant%0d", i), 32'(grant), 32'(fp_grant[i]));
        end
        req = 4'b0000;
        next_edge();
        check("fp_q3", 32'(q[3]), 32'h11);
        check("fp_q2", 32'(q[2]), 32'h22);
        exp_q0 = 8'h00;
`endif

        // Lone requester held high: grant every other cycle.
        req  = 4'b1000;
        addr = 8'b01_00_00_00;
        data = 32'h7700_0000;
        for (int i = 0; i < 4; i++) begin
            next_edge();
            check($sformatf("lone_grant%0d", i), 32'(grant), 32'(lone_grant[i]));
            check($sformatf("lone_busy%0d", i),  32'(busy),  32'(lone_busy[i]));
        end
        req = 4'b0000;
        next_edge();
        check("lone_q1", 32'(q[1]), 32'h77);

        // Out-of-range address on the three-register bank.
        req3  = 4'b0001;
        addr3 = 8'b00_00_00_11;
        data3 = 32'h0000_005A;
        next_edge();
        check("oor_grant", 32'(grant3), 32'h1);
        check("oor_en_b",  32'(en_b3),  32'h7);
        check("oor_dbus",  32'(d_bus3), 32'h5A);
        req3 = 4'b0000;
        next_edge();
        check("oor_grant0", 32'(grant3), 32'h0);
        check("oor_q0", 32'(q3[0]), 32'h00);
        check("oor_q1", 32'(q3[1]), 32'h00);
        check("oor_q2", 32'(q3[2]), 32'h00);

        // Reset during the grant cycle, before the capture edge.
        req  = 4'b0001;
        addr = 8'b00_00_00_00;
        data = 32'h0000_00EE;
        next_edge();
        check("mid_en_load", 32'(en_b), 32'hE);
        #3;
        clear_bar = 1'b0;
        #1;
        req = 4'b0000;
        check("mid_en_b",  32'(en_b),  32'hF);
        check("mid_grant", 32'(grant), 32'h0);
        check("mid_busy",  32'(busy),  32'h0);
        next_edge();
        next_edge();
        check("mid_q0", 32'(q[0]), 32'(exp_q0));
        clear_bar = 1'b1;
        next_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
